uart_tx: RTL and testbench

- Serial transmitter that drives the SOC's TXD pin, which is currently tied to 0; the CPU's memory-mapped I/O path feeds it bytes.
- Accepts bytes on a valid/ready write port and buffers them in a small FIFO.
- Serialises each byte as 8N1 asynchronous frames at a fixed bit period.
- Runs on the divided core clock (clk) and the matching resetn.

---
 rtl/uart_pkg.sv | 14 +
 rtl/uart_tx_byte_fifo.sv | 52 +++++
 rtl/uart_tx.sv | 128 ++++++++++++
 tb/tb_uart_tx.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and 8N1 frame constants.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;

endpackage

// File: rtl/uart_tx_byte_fifo.sv
// Synchronous byte FIFO with a combinational head read and occupancy count.
module byte_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     push,
  input  logic [7:0]               push_data,
  input  logic                     pop,
  output logic [7:0]               pop_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full     = (count == FULL_COUNT);
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: buffered write port feeding a registered-txd serialiser.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic [7:0]                    wr_data,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  output logic                          txd,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] DATA_LAST = IW'(DATA_BITS - 1);
  localparam logic [IW-1:0] STOP_LAST = IW'(STOP_BITS - 1);

  tx_state_t            state;
  logic [BW-1:0]        baud_cnt;
  logic [IW-1:0]        bit_idx;
  logic [DATA_BITS-1:0] sh;
  logic [7:0]           pop_data;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 fifo_pop;
  logic                 baud_done;
  logic                 frame_end;

  // Full means refuse, even if the serialiser pops on the same edge.
  assign wr_ready  = resetn && !fifo_full;
  assign baud_done = (baud_cnt == BAUD_LAST);
  assign frame_end = (state == STOP) && baud_done && (bit_idx == STOP_LAST);
  assign fifo_pop  = !fifo_empty && ((state == IDLE) || frame_end);
  assign busy      = (state != IDLE) || !fifo_empty;

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .push      (wr_valid && wr_ready),
    .push_data (wr_data),
    .pop       (fifo_pop),
    .pop_data  (pop_data),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // txd is loaded with the level of the state being entered, so it stays a pure flop.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      sh       <= '0;
      txd      <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          baud_cnt <= '0;
          if (!fifo_empty) begin
            sh    <= pop_data;
            state <= START;
            txd   <= 1'b0;
          end else begin
            txd   <= 1'b1;
          end
        end
        START: begin
          if (baud_done) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            state    <= DATA;
            txd      <= sh[0];
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end
        DATA: begin
          if (baud_done) begin
            baud_cnt <= '0;
            sh       <= sh >> 1;
            if (bit_idx == DATA_LAST) begin
              bit_idx <= '0;
              state   <= STOP;
              txd     <= 1'b1;
            end else begin
              bit_idx <= bit_idx + IW'(1);
              txd     <= sh[1];
            end
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end
        STOP: begin
          if (baud_done) begin
            baud_cnt <= '0;
            if (bit_idx == STOP_LAST) begin
              bit_idx <= '0;
              if (!fifo_empty) begin
                sh    <= pop_data;
                state <= START;
                txd   <= 1'b0;
              end else begin
                state <= IDLE;
                txd   <= 1'b1;
              end
            end else begin
              bit_idx <= bit_idx + IW'(1);
            end
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end
        default: begin
          state <= IDLE;
          txd   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx with CLKS_PER_BIT=4, FIFO_DEPTH=4.
module tb_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;

  logic       clk      = 1'b0;
  logic       resetn   = 1'b0;
  logic [7:0] wr_data  = 8'h00;
  logic       wr_valid = 1'b0;
  logic       wr_ready;
  logic       txd;
  logic       busy;
  logic [2:0] fifo_count;

  int checks = 0;
  int errors = 0;
  int bad;
  int stall;
  int bad_count;

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;
    string      name;
  } vec_t;

  vec_t       vecs[5];
  logic [9:0] full_frames[6];

  uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .wr_data    (wr_data),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .txd        (txd),
    .busy       (busy),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Called just after a negedge; returns at the negedge following the push edge.
  task automatic applyStimulus(input logic [7:0] data);
    int waited = 0;
    wr_valid = 1'b1;
    wr_data  = data;
    while (!wr_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!wr_ready) checkOutput("push timeout", 32'(wr_ready), 32'd1);
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  // Frame bits are start, data LSB first, stop; frame[0] is the start bit.
  task automatic checkFrame(input logic [9:0] frame, input string name);
    logic [3:0] seen;
    for (int s = 0; s < 10; s++) begin
      for (int c = 0; c < CPB; c++) begin
        seen[c] = txd;
        @(negedge clk);
      end
      checkOutput($sformatf("%s slot%0d", name, s), 32'(seen), 32'({4{frame[s]}}));
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0] = '{8'h55, 10'h2AA, "byte 55"};
    vecs[1] = '{8'h00, 10'h200, "byte 00"};
    vecs[2] = '{8'hFF, 10'h3FE, "byte FF"};
    vecs[3] = '{8'h80, 10'h300, "byte 80"};
    vecs[4] = '{8'h01, 10'h202, "byte 01"};
    full_frames[0] = 10'h202;
    full_frames[1] = 10'h204;
    full_frames[2] = 10'h206;
    full_frames[3] = 10'h208;
    full_frames[4] = 10'h20A;
    full_frames[5] = 10'h20C;

    $display("[TB] reset then idle");
    repeat (3) @(negedge clk);
    checkOutput("reset txd", 32'(txd), 32'd1);
    checkOutput("reset wr_ready", 32'(wr_ready), 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset fifo_count", 32'(fifo_count), 32'd0);
    resetn = 1'b1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (txd !== 1'b1 || busy !== 1'b0 || fifo_count !== 3'd0 || wr_ready !== 1'b1) bad++;
    end
    checkOutput("idle after release", 32'(bad), 32'd0);

    $display("[TB] single-byte frames");
    for (int v = 0; v < 5; v++) begin
      applyStimulus(vecs[v].data);
      checkOutput({vecs[v].name, " queued busy"}, 32'(busy), 32'd1);
      checkOutput({vecs[v].name, " queued count"}, 32'(fifo_count), 32'd1);
      checkOutput({vecs[v].name, " txd before start"}, 32'(txd), 32'd1);
      @(negedge clk);
      checkOutput({vecs[v].name, " popped count"}, 32'(fifo_count), 32'd0);
      checkFrame(vecs[v].frame, vecs[v].name);
      checkOutput({vecs[v].name, " busy after frame"}, 32'(busy), 32'd0);
      checkOutput({vecs[v].name, " txd after frame"}, 32'(txd), 32'd1);
    end

    $display("[TB] back-to-back frames");
    wr_valid = 1'b1;
    wr_data  = 8'hA3;
    @(negedge clk);
    wr_data  = 8'h0F;
    @(negedge clk);
    wr_valid = 1'b0;
    checkOutput("b2b count", 32'(fifo_count), 32'd1);
    checkFrame(10'h346, "b2b A3");
    checkFrame(10'h21E, "b2b 0F");
    checkOutput("b2b busy after", 32'(busy), 32'd0);

    $display("[TB] fifo full");
    stall     = 0;
    bad_count = 0;
    fork
      begin
        wr_valid = 1'b1;
        for (int i = 1; i <= 6; i++) begin
          wr_data = 8'(i);
          while (!wr_ready && stall < 300) begin
            if (fifo_count !== 3'd4) bad_count++;
            stall++;
            @(negedge clk);
          end
          @(negedge clk);
        end
        wr_valid = 1'b0;
        checkOutput("full stall cycles", 32'(stall), 32'd37);
        checkOutput("full count held at 4", 32'(bad_count), 32'd0);
      end
      begin
        repeat (2) @(negedge clk);
        for (int i = 0; i < 6; i++) checkFrame(full_frames[i], $sformatf("full byte%0d", i + 1));
      end
    join
    checkOutput("full busy after", 32'(busy), 32'd0);
    checkOutput("full count after", 32'(fifo_count), 32'd0);

    $display("[TB] simultaneous push and pop");
    fork
      begin
        wr_valid = 1'b1;
        wr_data  = 8'h3C;
        @(negedge clk);
        wr_data  = 8'h5A;
        @(negedge clk);
        wr_valid = 1'b0;
        checkOutput("pp count queued", 32'(fifo_count), 32'd1);
        repeat (39) @(negedge clk);
        checkOutput("pp count before stop edge", 32'(fifo_count), 32'd1);
        checkOutput("pp ready before stop edge", 32'(wr_ready), 32'd1);
        wr_valid = 1'b1;
        wr_data  = 8'h96;
        @(negedge clk);
        wr_valid = 1'b0;
        checkOutput("pp count after stop edge", 32'(fifo_count), 32'd1);
      end
      begin
        repeat (2) @(negedge clk);
        checkFrame(10'h278, "pp 3C");
        checkFrame(10'h2B4, "pp 5A");
        checkFrame(10'h32C, "pp 96");
      end
    join
    checkOutput("pp busy after", 32'(busy), 32'd0);

    $display("[TB] reset mid-frame");
    wr_valid = 1'b1;
    wr_data  = 8'hC3;
    @(negedge clk);
    wr_data  = 8'h11;
    @(negedge clk);
    wr_data  = 8'h22;
    @(negedge clk);
    wr_valid = 1'b0;
    repeat (16) @(negedge clk);
    checkOutput("midframe data bit3", 32'(txd), 32'd0);
    checkOutput("midframe count", 32'(fifo_count), 32'd2);
    #1 resetn = 1'b0;
    #1;
    checkOutput("async reset txd", 32'(txd), 32'd1);
    checkOutput("async reset count", 32'(fifo_count), 32'd0);
    checkOutput("async reset busy", 32'(busy), 32'd0);
    checkOutput("async reset wr_ready", 32'(wr_ready), 32'd0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    bad = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (txd !== 1'b1 || busy !== 1'b0 || fifo_count !== 3'd0) bad++;
    end
    checkOutput("quiet after reset", 32'(bad), 32'd0);
    checkOutput("ready after reset", 32'(wr_ready), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
